// File: rtl/ram_wait_ctrl_pkg.sv
// Shared definitions for the wait-state memory controller: access type codes
// (also used by the CU), FSM states and small decode helpers.
package ram_wait_ctrl_pkg;

    localparam logic [1:0] TYPE_BYTE = 2'b00;
    localparam logic [1:0] TYPE_HALF = 2'b01;
    localparam logic [1:0] TYPE_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_DONE = 2'b10
    } state_t;

    // Big-endian byte-lane enables: bit 3 is the byte at the base address.
    function automatic logic [3:0] lane_enables(input logic [1:0] t);
        case (t)
            TYPE_BYTE: return 4'b1000;
            TYPE_HALF: return 4'b1100;
            default:   return 4'b1111;
        endcase
    endfunction

    // Access size in bytes minus one (0, 1 or 3); 2'b11 is treated as a word.
    function automatic logic [1:0] size_minus1(input logic [1:0] t);
        case (t)
            TYPE_BYTE: return 2'd0;
            TYPE_HALF: return 2'd1;
            default:   return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/ram_wait_ctrl_mem_array_be.sv
// DEPTH x 8 byte array with a big-endian 4-lane port: synchronous write under
// per-lane enables and a combinational 4-byte read. Lanes that fall past the
// top of the array read as zero and are never written (no wrap-around).
module mem_array_be
    import ram_wait_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        be,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    // Kept under this name so a bench can preload or inspect it hierarchically.
    logic [7:0] mem [DEPTH];

    logic [ADDR_W:0] lane_addr [4];
    logic [3:0]      lane_ok;
    logic [3:0]      lane_we;

    // Per-lane byte address (addr + lane) with a carry bit for range detection.
    always_comb begin
        for (int unsigned k = 0; k < 4; k++) begin
            lane_addr[k] = {1'b0, addr} + {{(ADDR_W - 1){1'b0}}, 2'(k)};
            lane_ok[k]   = ~lane_addr[k][ADDR_W];
            lane_we[k]   = we & be[3 - k] & ~lane_addr[k][ADDR_W];
        end
    end

    // Lane k carries the byte at addr+k, i.e. data bits [31-8k -: 8].
    always_comb begin
        rdata = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            if (lane_ok[k]) begin
                rdata[8 * (3 - k) +: 8] = mem[lane_addr[k][ADDR_W-1:0]];
            end
        end
    end

    // Byte-lane write; the array has no reset so contents survive CLR.
    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < 4; k++) begin
            if (lane_we[k]) begin
                mem[lane_addr[k][ADDR_W-1:0]] <= wdata[8 * (3 - k) +: 8];
            end
        end
    end

endmodule

// File: rtl/ram_wait_ctrl.sv
// Byte-addressed big-endian memory on the CPU memory port with a MOV/MOC
// handshake, programmable wait states, alignment/range error reporting and
// sign/zero extension of byte and halfword reads.
module ram_wait_ctrl
    import ram_wait_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned ALIGN_CHECK = 1
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              MOV,
    input  logic              RW,
    input  logic [1:0]        typeData,
    input  logic              SGN,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] DataIn,
    output logic [DATA_W-1:0] DataOut,
    output logic              MOC,
    output logic              ERR
);

    localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [3:0] LAST_CNT  = ZERO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);
    localparam bit         DO_ALIGN  = (ALIGN_CHECK != 0);

    state_t            state;
    logic [3:0]        cnt;
    logic              err_q;

    logic              q_rw;
    logic              q_sgn;
    logic [1:0]        q_type;
    logic [ADDR_W-1:0] q_addr;
    logic [DATA_W-1:0] q_din;

    logic              s_rw;
    logic              s_sgn;
    logic [1:0]        s_type;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_din;

    logic              exec;
    logic              misaligned;
    logic              out_of_range;
    logic              acc_err;
    logic [ADDR_W:0]   end_addr;
    logic [31:0]       wr_data;
    logic [31:0]       rd_word;
    logic [31:0]       rd_ext;

    // With zero wait states the access executes on the accepting edge itself,
    // so the live port values are used there; otherwise the latched request.
    always_comb begin
        if (state == S_IDLE) begin
            s_rw   = RW;
            s_sgn  = SGN;
            s_type = typeData;
            s_addr = Address;
            s_din  = DataIn;
        end else begin
            s_rw   = q_rw;
            s_sgn  = q_sgn;
            s_type = q_type;
            s_addr = q_addr;
            s_din  = q_din;
        end
    end

    // Execute strobe, alignment/range check and write-lane alignment.
    always_comb begin
        exec = ((state == S_IDLE) && MOV && ZERO_WAIT) ||
               ((state == S_WAIT) && (cnt == LAST_CNT));

        misaligned = DO_ALIGN &&
                     (((s_type == TYPE_HALF) && s_addr[0]) ||
                      (s_type[1] && (s_addr[1:0] != 2'b00)));

        end_addr     = {1'b0, s_addr} + {{(ADDR_W - 1){1'b0}}, size_minus1(s_type)};
        out_of_range = end_addr[ADDR_W];
        acc_err      = misaligned | out_of_range;

        case (s_type)
            TYPE_BYTE: wr_data = {s_din[7:0], 24'h000000};
            TYPE_HALF: wr_data = {s_din[15:0], 16'h0000};
            default:   wr_data = s_din[31:0];
        endcase
    end

    // Right-justify the big-endian read and extend per SGN.
    always_comb begin
        case (s_type)
            TYPE_BYTE: rd_ext = {{24{s_sgn & rd_word[31]}}, rd_word[31:24]};
            TYPE_HALF: rd_ext = {{16{s_sgn & rd_word[31]}}, rd_word[31:16]};
            default:   rd_ext = rd_word;
        endcase
    end

    mem_array_be #(
        .ADDR_W(ADDR_W)
    ) u_mem (
        .clk  (CLK),
        .we   (exec & ~s_rw & ~acc_err),
        .addr (s_addr),
        .be   (lane_enables(s_type)),
        .wdata(wr_data),
        .rdata(rd_word)
    );

    // Handshake FSM: request latch, wait counter, read data and MOC/ERR.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state   <= S_IDLE;
            cnt     <= '0;
            err_q   <= 1'b0;
            MOC     <= 1'b0;
            ERR     <= 1'b0;
            DataOut <= '0;
            q_rw    <= 1'b0;
            q_sgn   <= 1'b0;
            q_type  <= '0;
            q_addr  <= '0;
            q_din   <= '0;
        end else begin
            if (exec) begin
                err_q <= acc_err;
                if (acc_err) begin
                    DataOut <= '0;
                end else if (s_rw) begin
                    DataOut <= rd_ext;
                end
            end

            case (state)
                S_IDLE: begin
                    if (MOV) begin
                        q_rw   <= RW;
                        q_sgn  <= SGN;
                        q_type <= typeData;
                        q_addr <= Address;
                        q_din  <= DataIn;
                        cnt    <= '0;
                        state  <= ZERO_WAIT ? S_DONE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == LAST_CNT) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // MOC rises one edge after entering DONE and is held
                    // until the CU releases MOV; a MOV already dropped during
                    // WAIT therefore yields a single-cycle MOC pulse.
                    if (!MOC) begin
                        MOC <= 1'b1;
                        ERR <= err_q;
                    end else if (!MOV) begin
                        MOC   <= 1'b0;
                        ERR   <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
